// File: rtl/branch_lut_pkg.sv
// Shared definitions for the branch LUT loader: default widths, loader FSM
// states and frame field helpers.
package branch_lut_pkg;

    localparam int IDX_W_DEF  = 8;
    localparam int ADDR_W_DEF = 9;

    // The LO byte supplies the low 8 bits of the target; HI supplies the rest.
    localparam int LO_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_IDX,
        S_HI,
        S_LO,
        S_CSUM,
        S_DONE,
        S_ERR
    } loader_state_t;

    // HI-byte bits that have no place in an addr_w-bit target and must be zero.
    function automatic logic [7:0] hi_mask(input int addr_w);
        return 8'hFF << (addr_w - LO_BITS);
    endfunction

endpackage

// File: rtl/lut_frame_csum.sv
// XOR accumulator over frame bytes; compares the running value against the
// trailing checksum byte.
module lut_frame_csum (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic       match
);

    logic [7:0] acc;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

    assign match = (acc == din);

endmodule

// File: rtl/branch_lut_loader.sv
// Parses a COUNT / (IDX,HI,LO)* / CSUM byte stream and issues one branch LUT
// write per entry, flagging done or err when the frame ends.
module branch_lut_loader
    import branch_lut_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_index,
    output logic [ADDR_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [IDX_W:0]    entries
);

    localparam int             HI_W       = ADDR_W - LO_BITS;
    localparam logic [7:0]     HI_ILLEGAL = hi_mask(ADDR_W);
    localparam logic [IDX_W:0] ONE        = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] FULL_LOAD  = (IDX_W+1)'(256);

    loader_state_t   state, state_next;
    logic [IDX_W:0]  remaining;
    logic [IDX_W-1:0] idx_q;
    logic [HI_W-1:0] hi_q;
    logic            accept;
    logic            start_ok;
    logic            csum_match;

    // Ready is a pure function of state so it never depends on in_valid.
    assign busy     = (state inside {S_COUNT, S_IDX, S_HI, S_LO, S_CSUM});
    assign in_ready = busy;
    assign accept   = in_valid && in_ready;
    assign start_ok = start && !busy;
    assign done     = (state == S_DONE);
    assign err      = (state == S_ERR);

    lut_frame_csum u_csum (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (start_ok),
        .en      (accept && (state != S_CSUM)),
        .din     (in_data),
        .match   (csum_match)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state gets its default first so no path through the case
    // leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (start) state_next = S_COUNT;
            S_COUNT: if (accept) state_next = S_IDX;
            S_IDX:   if (accept) state_next = S_HI;
            S_HI:    if (accept) state_next = ((in_data & HI_ILLEGAL) != 8'h00) ? S_ERR : S_LO;
            S_LO:    if (accept) state_next = (remaining == ONE) ? S_CSUM : S_IDX;
            S_CSUM:  if (accept) state_next = csum_match ? S_DONE : S_ERR;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_en     <= 1'b0;
            wr_index  <= '0;
            wr_data   <= '0;
            entries   <= '0;
            remaining <= '0;
            idx_q     <= '0;
            hi_q      <= '0;
        end else begin
            wr_en <= 1'b0;
            if (start_ok) begin
                entries   <= '0;
                remaining <= '0;
            end
            if (accept) begin
                case (state)
                    // A zero count means a full 256-entry table.
                    S_COUNT: remaining <= (in_data == 8'h00) ? FULL_LOAD : (IDX_W+1)'(in_data);
                    S_IDX:   idx_q <= IDX_W'(in_data);
                    S_HI:    hi_q  <= in_data[HI_W-1:0];
                    S_LO: begin
                        wr_en     <= 1'b1;
                        wr_index  <= idx_q;
                        wr_data   <= {hi_q, in_data};
                        entries   <= entries + ONE;
                        remaining <= remaining - ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_lut_loader.sv
// Scenario bench for branch_lut_loader: writes are scoreboarded, flags and
// counters compared after each frame.
module tb_branch_lut_loader;
    import branch_lut_pkg::*;

    localparam int IDX_W  = 8;
    localparam int ADDR_W = 9;
    localparam int BUDGET = 50;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_index;
    logic [ADDR_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [IDX_W:0]    entries;

    int checks = 0;
    int errors = 0;
    int busy_cycles = 0;

    logic [IDX_W+ADDR_W-1:0] exp_q[$];
    logic [7:0] ent_idx [256];
    logic [7:0] ent_hi  [256];
    logic [7:0] ent_lo  [256];

    branch_lut_loader #(.IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_index (wr_index),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .entries  (entries)
    );

    always #5 clk = ~clk;

    // Every clock advance goes through here; writes are scoreboarded 1 unit after the edge.
    task automatic tick();
        logic [IDX_W+ADDR_W-1:0] exp;
        @(posedge clk);
        #1;
        if (busy) busy_cycles++;
        if (wr_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got idx=%0h data=%0h expected none", wr_index, wr_data);
            end else begin
                exp = exp_q.pop_front();
                if ({wr_index, wr_data} !== exp) begin
                    errors++;
                    $display("FAIL write_value got idx=%0h data=%0h expected idx=%0h data=%0h",
                             wr_index, wr_data, exp[IDX_W+ADDR_W-1:ADDR_W], exp[ADDR_W-1:0]);
                end
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n;
        if (stall) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < BUDGET) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready=%b expected 1 within %0d cycles", in_ready, BUDGET);
        end else begin
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Sends a frame from ent_* arrays; csum_byte < 0 means use the correct checksum.
    // Returns early after an illegal HI byte, mirroring the loader aborting.
    task automatic run_frame(input int n, input bit stall, input int csum_byte);
        logic [7:0] cs;
        logic [7:0] cnt;
        int k;
        cs  = 8'h00;
        cnt = n[7:0];
        k   = 0;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || err !== 1'b0 || entries !== '0) begin
            errors++;
            $display("FAIL start_clear got busy=%b done=%b err=%b entries=%0d expected 1 0 0 0",
                     busy, done, err, entries);
        end
        send_byte(cnt, stall && (k++ % 2 == 1));
        cs ^= cnt;
        for (int i = 0; i < n; i++) begin
            send_byte(ent_idx[i], stall && (k++ % 2 == 1));
            send_byte(ent_hi[i], stall && (k++ % 2 == 1));
            if ((ent_hi[i] & 8'hFE) != 8'h00) return;
            exp_q.push_back({ent_idx[i], ent_hi[i][0], ent_lo[i]});
            send_byte(ent_lo[i], stall && (k++ % 2 == 1));
            cs ^= ent_idx[i] ^ ent_hi[i] ^ ent_lo[i];
        end
        send_byte((csum_byte < 0) ? cs : csum_byte[7:0], stall && (k++ % 2 == 1));
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({in_ready, busy, wr_en, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got rdy=%b busy=%b wr_en=%b done=%b err=%b expected all 0",
                     in_ready, busy, wr_en, done, err);
        end
        checks++;
        if (wr_index !== '0 || wr_data !== '0 || entries !== '0) begin
            errors++;
            $display("FAIL reset_regs got idx=%0h data=%0h entries=%0d expected 0 0 0",
                     wr_index, wr_data, entries);
        end
        reset_n = 1'b1;
        tick();
        in_valid = 1'b1;
        in_data  = 8'h01;
        tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_accept got rdy=%b busy=%b expected 0 0", in_ready, busy);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_single();
        ent_idx[0] = 8'h05; ent_hi[0] = 8'h01; ent_lo[0] = 8'h2C;
        run_frame(1, 1'b0, -1);
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || entries !== 9'd1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_flags got done=%b err=%b entries=%0d busy=%b rdy=%b expected 1 0 1 0 0",
                     done, err, entries, busy, in_ready);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_missing got %0d pending writes expected 0", exp_q.size());
        end
    endtask

    task automatic test_stall();
        ent_idx[0] = 8'h10; ent_hi[0] = 8'h00; ent_lo[0] = 8'hAB;
        ent_idx[1] = 8'h20; ent_hi[1] = 8'h01; ent_lo[1] = 8'hFF;
        ent_idx[2] = 8'h10; ent_hi[2] = 8'h00; ent_lo[2] = 8'h55;
        run_frame(3, 1'b1, -1);
        tick();
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || entries !== 9'd3) begin
            errors++;
            $display("FAIL stall_flags got done=%b err=%b entries=%0d expected 1 0 3", done, err, entries);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_missing got %0d pending writes expected 0", exp_q.size());
        end
    endtask

    task automatic test_bad_csum();
        ent_idx[0] = 8'h07; ent_hi[0] = 8'h00; ent_lo[0] = 8'h10;
        run_frame(1, 1'b0, 8'hFF);
        tick();
        tick();
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || entries !== 9'd1) begin
            errors++;
            $display("FAIL csum_flags got err=%b done=%b entries=%0d expected 1 0 1", err, done, entries);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL csum_missing got %0d pending writes expected 0", exp_q.size());
        end
    endtask

    task automatic test_bad_hi();
        ent_idx[0] = 8'h03; ent_hi[0] = 8'h00; ent_lo[0] = 8'h44;
        ent_idx[1] = 8'h04; ent_hi[1] = 8'h02; ent_lo[1] = 8'h55;
        ent_idx[2] = 8'h06; ent_hi[2] = 8'h00; ent_lo[2] = 8'h66;
        run_frame(3, 1'b0, -1);
        checks++;
        if (err !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || entries !== 9'd1) begin
            errors++;
            $display("FAIL badhi_flags got err=%b rdy=%b done=%b entries=%0d expected 1 0 0 1",
                     err, in_ready, done, entries);
        end
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 4; i++) tick();
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || err !== 1'b1 || entries !== 9'd1) begin
            errors++;
            $display("FAIL badhi_hold got rdy=%b err=%b entries=%0d expected 0 1 1", in_ready, err, entries);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL badhi_missing got %0d pending writes expected 0", exp_q.size());
        end
    endtask

    task automatic test_full_table();
        for (int i = 0; i < 256; i++) begin
            ent_idx[i] = i[7:0];
            ent_hi[i]  = 8'h01;
            ent_lo[i]  = i[7:0];
        end
        busy_cycles = 0;
        run_frame(256, 1'b0, -1);
        checks++;
        if (busy_cycles != 3 * 256 + 2) begin
            errors++;
            $display("FAIL full_busy got %0d cycles expected %0d", busy_cycles, 3 * 256 + 2);
        end
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || entries !== 9'd256) begin
            errors++;
            $display("FAIL full_flags got done=%b err=%b entries=%0d expected 1 0 256", done, err, entries);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_missing got %0d pending writes expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h09, 1'b0);
        reset_n = 1'b0;
        tick();
        checks++;
        if ({in_ready, busy, wr_en, done, err} !== 5'b0 || wr_index !== '0 || wr_data !== '0 || entries !== '0) begin
            errors++;
            $display("FAIL midreset got rdy=%b busy=%b wr_en=%b done=%b err=%b idx=%0h data=%0h entries=%0d expected all 0",
                     in_ready, busy, wr_en, done, err, wr_index, wr_data, entries);
        end
        reset_n = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle got busy=%b done=%b err=%b expected 0 0 0", busy, done, err);
        end
        // Second start arrives mid-frame and must not restart parsing.
        pulse_start();
        send_byte(8'h01, 1'b0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || entries !== '0) begin
            errors++;
            $display("FAIL start_busy got busy=%b entries=%0d expected 1 0", busy, entries);
        end
        send_byte(8'h0A, 1'b0);
        send_byte(8'h01, 1'b0);
        exp_q.push_back({8'h0A, 1'b1, 8'h00});
        send_byte(8'h00, 1'b0);
        send_byte(8'h01 ^ 8'h0A ^ 8'h01 ^ 8'h00, 1'b0);
        tick();
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || entries !== 9'd1) begin
            errors++;
            $display("FAIL reload_flags got done=%b err=%b entries=%0d expected 1 0 1", done, err, entries);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reload_missing got %0d pending writes expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_bad_csum();
        test_bad_hi();
        test_full_table();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
